// File: rtl/csa_seq_ctrl_if.sv
// Request/response handshake bundle for the csa sequencer.
// The requester drives operands and out_ready; the sequencer returns the result.
interface csa_seq_ctrl_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_seq_ctrl.sv
// Multi-cycle W-bit adder that reuses one external 4-bit carry-select slice,
// feeding one nibble per cycle and resolving the slice's dual carries LSB-first.
module csa_seq_ctrl #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  csa_seq_ctrl_if.slave    bus,
  output logic             slice_sel,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  input  logic [3:0]       slice_s,
  input  logic             slice_c0,
  input  logic             slice_c1
);

  localparam int NSL = W / 4;
  localparam int CW  = $clog2(NSL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   areg;
  logic [W-1:0]   breg;
  logic [W-1:0]   sreg;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic           sa;
  logic           sb;
  logic [W-1:0]   sum_q;
  logic           cout_q;
  logic           ovf_q;

  logic           accept;
  logic           last_pass;
  logic           carry_next;

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_pass  = (state == RUN) && (cnt == CW'(NSL - 1));
  assign carry_next = carry ? slice_c1 : slice_c0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_pass)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // The slice is only driven while a pass is in flight so it sees zeros when idle.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.sum       = sum_q;
    bus.cout      = cout_q;
    bus.ovf       = ovf_q;
    slice_sel     = 1'b0;
    slice_a       = 4'd0;
    slice_b       = 4'd0;
    if (state == RUN) begin
      slice_sel = carry;
      slice_a   = areg[3:0];
      slice_b   = breg[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg  <= '0;
      breg  <= '0;
      sreg  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
    end else if (accept) begin
      areg  <= bus.a;
      breg  <= bus.b;
      carry <= bus.cin;
      sa    <= bus.a[W-1];
      sb    <= bus.b[W-1];
      cnt   <= '0;
    end else if (state == RUN) begin
      sreg  <= {slice_s, sreg[W-1:4]};
      carry <= carry_next;
      areg  <= areg >> 4;
      breg  <= breg >> 4;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result registers load on the final pass so they hold through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last_pass) begin
      sum_q  <= {slice_s, sreg[W-1:4]};
      cout_q <= carry_next;
      ovf_q  <= (sa == sb) && (slice_s[3] != sa);
    end
  end

endmodule
